// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path: state codes, ALU op
// codes, instruction decode fields and datapath select encodings.
package mips_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_I_EXEC   = 4'd8;
    localparam logic [3:0] S_I_WB     = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_JAL      = 4'd12;
    localparam logic [3:0] S_JR       = 4'd13;
    localparam logic [3:0] S_HALT     = 4'd14;
    // Not a real state: dispatch result for an unsupported instruction.
    localparam logic [3:0] S_BAD      = 4'd15;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_PASS_B = 3'b001;
    localparam logic [2:0] ALU_NOT_B  = 3'b010;
    localparam logic [2:0] ALU_ADD    = 3'b100;
    localparam logic [2:0] ALU_SUB    = 3'b101;
    localparam logic [2:0] ALU_AND    = 3'b110;
    localparam logic [2:0] ALU_OR     = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    // Next state out of DECODE; S_BAD marks an unsupported instruction.
    function automatic logic [3:0] dispatch_state(input logic [5:0] opcode,
                                                  input logic [5:0] funct);
        logic [3:0] ns;
        ns = S_BAD;
        case (opcode)
            OP_LW, OP_SW:             ns = S_MEM_ADDR;
            OP_ADDI, OP_ANDI, OP_ORI: ns = S_I_EXEC;
            OP_BEQ, OP_BNE:           ns = S_BRANCH;
            OP_J:                     ns = S_JUMP;
            OP_JAL:                   ns = S_JAL;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR: ns = S_R_EXEC;
                    FN_JR:                         ns = S_JR;
                    default:                       ns = S_BAD;
                endcase
            end
            default:                  ns = S_BAD;
        endcase
        return ns;
    endfunction

endpackage

// File: rtl/mips_alu_op_dec.sv
// ALU operation and immediate-extension decode, driven from the current state
// and the instruction fields held in the IR.
module mips_alu_op_dec
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] aluOp,
    output logic       immZext
);

    always_comb begin
        aluOp   = ALU_ADD;
        immZext = 1'b0;
        case (state)
            S_R_EXEC: begin
                case (funct)
                    FN_SUB:  aluOp = ALU_SUB;
                    FN_AND:  aluOp = ALU_AND;
                    FN_OR:   aluOp = ALU_OR;
                    default: aluOp = ALU_ADD;
                endcase
            end
            S_I_EXEC: begin
                case (opcode)
                    OP_ANDI: begin
                        aluOp   = ALU_AND;
                        immZext = 1'b1;
                    end
                    OP_ORI: begin
                        aluOp   = ALU_OR;
                        immZext = 1'b1;
                    end
                    default: aluOp = ALU_ADD;
                endcase
            end
            // Extension mode stays valid while ALUOut is written back.
            S_I_WB:   immZext = (opcode == OP_ANDI) || (opcode == OP_ORI);
            S_BRANCH: aluOp = ALU_SUB;
            S_JR:     aluOp = ALU_PASS_A;
            default:  aluOp = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Main control FSM of the multi-cycle MIPS datapath. Outputs decode from state;
// pcWrite/irWrite and branch resolution also follow memReady/zero directly.
module mips_mc_controller
    import mips_ctrl_pkg::*;
#(
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memReady,
    output logic       memRead,
    output logic       memWrite,
    output logic       iorD,
    output logic       irWrite,
    output logic       pcWrite,
    output logic [1:0] pcSrc,
    output logic       regWrite,
    output logic [1:0] regDst,
    output logic [1:0] memToReg,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic       immZext,
    output logic [2:0] aluOp,
    output logic       illegal,
    output logic [3:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [5:0] op_q;
    logic [3:0] dispatch;
    logic [2:0] dec_aluop;
    logic       dec_immzext;

    assign state    = state_q;
    assign dispatch = dispatch_state(opcode, funct);

    mips_alu_op_dec u_alu_op_dec (
        .state   (state_q),
        .opcode  (opcode),
        .funct   (funct),
        .aluOp   (dec_aluop),
        .immZext (dec_immzext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= OP_RTYPE;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // Memory handshake: a strobe (memRead/memWrite) is held high until the
    // cycle memReady is seen; that cycle completes the access and advances.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (memReady) state_d = S_DECODE;
            S_DECODE: begin
                if (dispatch == S_BAD) begin
                    state_d = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
                end else begin
                    state_d = dispatch;
                end
            end
            S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (memReady) state_d = S_MEM_WB;
            S_MEM_WR:   if (memReady) state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR:
                        state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        memRead  = 1'b0;
        memWrite = 1'b0;
        iorD     = 1'b0;
        irWrite  = 1'b0;
        pcWrite  = 1'b0;
        pcSrc    = PCSRC_ALU;
        regWrite = 1'b0;
        regDst   = REGDST_RT;
        memToReg = M2R_ALUOUT;
        aluSrcA  = 1'b0;
        aluSrcB  = SRCB_REGB;
        immZext  = 1'b0;
        aluOp    = ALU_ADD;
        illegal  = 1'b0;
        // Reset forces every strobe low even though the state reads FETCH.
        if (rst_n) begin
            aluOp   = dec_aluop;
            immZext = dec_immzext;
            case (state_q)
                S_FETCH: begin
                    memRead = 1'b1;
                    aluSrcB = SRCB_FOUR;
                    irWrite = memReady;
                    pcWrite = memReady;
                end
                S_DECODE: begin
                    aluSrcB = SRCB_BRIMM;
                    illegal = (dispatch == S_BAD);
                end
                S_MEM_ADDR: begin
                    aluSrcA = 1'b1;
                    aluSrcB = SRCB_IMM;
                end
                S_MEM_RD: begin
                    iorD    = 1'b1;
                    memRead = 1'b1;
                end
                S_MEM_WB: begin
                    regDst   = REGDST_RT;
                    memToReg = M2R_MDR;
                    regWrite = 1'b1;
                end
                S_MEM_WR: begin
                    iorD     = 1'b1;
                    memWrite = 1'b1;
                end
                S_R_EXEC: begin
                    aluSrcA = 1'b1;
                    aluSrcB = SRCB_REGB;
                end
                S_R_WB: begin
                    regDst   = REGDST_RD;
                    memToReg = M2R_ALUOUT;
                    regWrite = 1'b1;
                end
                S_I_EXEC: begin
                    aluSrcA = 1'b1;
                    aluSrcB = SRCB_IMM;
                end
                S_I_WB: begin
                    regDst   = REGDST_RT;
                    memToReg = M2R_ALUOUT;
                    regWrite = 1'b1;
                end
                S_BRANCH: begin
                    aluSrcA = 1'b1;
                    aluSrcB = SRCB_REGB;
                    pcSrc   = PCSRC_ALUOUT;
                    pcWrite = (opcode == OP_BNE) ? ~zero : zero;
                end
                S_JUMP: begin
                    pcSrc   = PCSRC_JUMP;
                    pcWrite = 1'b1;
                end
                // PC already holds PC+4, which is the link value for $31.
                S_JAL: begin
                    pcSrc    = PCSRC_JUMP;
                    pcWrite  = 1'b1;
                    regWrite = 1'b1;
                    regDst   = REGDST_RA;
                    memToReg = M2R_PC;
                end
                S_JR: begin
                    aluSrcA = 1'b1;
                    pcSrc   = PCSRC_ALU;
                    pcWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: one instance refetches on an illegal
// opcode, a second one halts; both share the same stimulus.
module tb_mips_mc_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       memReady;

    logic       memRead, memWrite, iorD, irWrite, pcWrite, regWrite;
    logic       aluSrcA, immZext, illegal;
    logic [1:0] pcSrc, regDst, memToReg, aluSrcB;
    logic [2:0] aluOp;
    logic [3:0] state;

    logic       h_memRead, h_memWrite, h_iorD, h_irWrite, h_pcWrite, h_regWrite;
    logic       h_aluSrcA, h_immZext, h_illegal;
    logic [1:0] h_pcSrc, h_regDst, h_memToReg, h_aluSrcB;
    logic [2:0] h_aluOp;
    logic [3:0] h_state;

    int n_checks;
    int n_fail;

    mips_mc_controller #(.HALT_ON_ILLEGAL(0)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .memReady(memReady), .memRead(memRead), .memWrite(memWrite), .iorD(iorD),
        .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .regWrite(regWrite),
        .regDst(regDst), .memToReg(memToReg), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .immZext(immZext), .aluOp(aluOp), .illegal(illegal), .state(state)
    );

    mips_mc_controller #(.HALT_ON_ILLEGAL(1)) dut_halt (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .memReady(memReady), .memRead(h_memRead), .memWrite(h_memWrite),
        .iorD(h_iorD), .irWrite(h_irWrite), .pcWrite(h_pcWrite), .pcSrc(h_pcSrc),
        .regWrite(h_regWrite), .regDst(h_regDst), .memToReg(h_memToReg),
        .aluSrcA(h_aluSrcA), .aluSrcB(h_aluSrcB), .immZext(h_immZext),
        .aluOp(h_aluOp), .illegal(h_illegal), .state(h_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; checks land 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fetch_and_decode(input logic [5:0] op, input logic [5:0] fn);
        opcode   = op;
        funct    = fn;
        memReady = 1'b1;
        #1;
        chk("fetch_state", state, 4'd0);
        chk("fetch_irwrite", irWrite, 1);
        tick();
        chk("decode_state", state, 4'd1);
        chk("decode_srcb", aluSrcB, 2'b11);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        opcode   = 6'h00;
        funct    = 6'h00;
        zero     = 1'b0;
        memReady = 1'b1;

        // reset state
        tick();
        tick();
        chk("rst_state", state, 4'd0);
        chk("rst_memread", memRead, 0);
        chk("rst_irwrite", irWrite, 0);
        chk("rst_pcwrite", pcWrite, 0);
        chk("rst_aluop", aluOp, 3'b100);
        chk("rst_illegal", illegal, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_state", state, 4'd0);
        chk("rel_memread", memRead, 1);
        chk("rel_srcb", aluSrcB, 2'b01);
        chk("rel_pcwrite", pcWrite, 1);

        // lw with a 3-cycle memory stall
        fetch_and_decode(6'h23, 6'h00);
        tick();
        chk("lw_addr_state", state, 4'd2);
        chk("lw_addr_srca", aluSrcA, 1);
        chk("lw_addr_srcb", aluSrcB, 2'b10);
        memReady = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            memReady = (i == 3);
            #1;
            chk("lw_rd_state", state, 4'd3);
            chk("lw_rd_memread", memRead, 1);
            chk("lw_rd_iord", iorD, 1);
            chk("lw_rd_regwrite", regWrite, 0);
            tick();
        end
        chk("lw_wb_state", state, 4'd4);
        chk("lw_wb_regwrite", regWrite, 1);
        chk("lw_wb_regdst", regDst, 2'b00);
        chk("lw_wb_memtoreg", memToReg, 2'b01);
        tick();
        chk("lw_done_state", state, 4'd0);
        chk("lw_done_regwrite", regWrite, 0);

        // R-type sub and or
        fetch_and_decode(6'h00, 6'h22);
        tick();
        chk("sub_state", state, 4'd6);
        chk("sub_aluop", aluOp, 3'b101);
        chk("sub_srcb", aluSrcB, 2'b00);
        chk("sub_srca", aluSrcA, 1);
        tick();
        chk("sub_wb_state", state, 4'd7);
        chk("sub_wb_regdst", regDst, 2'b01);
        chk("sub_wb_regwrite", regWrite, 1);
        tick();
        fetch_and_decode(6'h00, 6'h25);
        tick();
        chk("or_aluop", aluOp, 3'b111);
        tick();
        tick();

        // ori: zero-extended immediate through writeback
        fetch_and_decode(6'h0D, 6'h00);
        tick();
        chk("ori_state", state, 4'd8);
        chk("ori_aluop", aluOp, 3'b111);
        chk("ori_zext", immZext, 1);
        tick();
        chk("ori_wb_zext", immZext, 1);
        chk("ori_wb_regdst", regDst, 2'b00);
        tick();

        // beq taken, bne with zero set
        zero = 1'b1;
        fetch_and_decode(6'h04, 6'h00);
        tick();
        chk("beq_state", state, 4'd10);
        chk("beq_pcwrite", pcWrite, 1);
        chk("beq_pcsrc", pcSrc, 2'b01);
        chk("beq_aluop", aluOp, 3'b101);
        tick();
        chk("beq_next", state, 4'd0);
        fetch_and_decode(6'h05, 6'h00);
        tick();
        chk("bne_z1_pcwrite", pcWrite, 0);
        zero = 1'b0;
        #1;
        chk("bne_z0_pcwrite", pcWrite, 1);
        tick();
        chk("bne_next", state, 4'd0);

        // jumps
        fetch_and_decode(6'h02, 6'h00);
        tick();
        chk("j_state", state, 4'd11);
        chk("j_pcsrc", pcSrc, 2'b10);
        chk("j_pcwrite", pcWrite, 1);
        tick();
        fetch_and_decode(6'h03, 6'h00);
        tick();
        chk("jal_state", state, 4'd12);
        chk("jal_regdst", regDst, 2'b10);
        chk("jal_memtoreg", memToReg, 2'b10);
        chk("jal_pcsrc", pcSrc, 2'b10);
        chk("jal_pcwrite", pcWrite, 1);
        chk("jal_regwrite", regWrite, 1);
        tick();
        fetch_and_decode(6'h00, 6'h08);
        tick();
        chk("jr_state", state, 4'd13);
        chk("jr_aluop", aluOp, 3'b000);
        chk("jr_pcsrc", pcSrc, 2'b00);
        chk("jr_pcwrite", pcWrite, 1);
        tick();
        chk("jr_next", state, 4'd0);

        // sw stalled, then reset mid-access
        fetch_and_decode(6'h2B, 6'h00);
        tick();
        memReady = 1'b0;
        tick();
        chk("sw_state", state, 4'd5);
        chk("sw_memwrite", memWrite, 1);
        tick();
        chk("sw_stall_state", state, 4'd5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("sw_rst_state", state, 4'd0);
        chk("sw_rst_memwrite", memWrite, 0);
        chk("sw_rst_memread", memRead, 0);
        chk("sw_rst_aluop", aluOp, 3'b100);
        tick();
        rst_n = 1'b1;
        #1;
        chk("sw_rel_state", state, 4'd0);
        chk("sw_rel_memread", memRead, 1);

        // illegal opcode: refetch vs halt
        fetch_and_decode(6'h3F, 6'h00);
        chk("ill_pulse", illegal, 1);
        chk("ill_pulse_halt", h_illegal, 1);
        tick();
        chk("ill_refetch", state, 4'd0);
        chk("ill_clear", illegal, 0);
        chk("ill_halt_state", h_state, 4'd14);
        for (int i = 0; i < 10; i++) begin
            chk("halt_state", h_state, 4'd14);
            chk("halt_memread", h_memRead, 0);
            chk("halt_pcwrite", h_pcWrite, 0);
            chk("halt_illegal", h_illegal, 0);
            tick();
        end
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        chk("halt_rst_state", h_state, 4'd0);
        chk("halt_rst_memread", h_memRead, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Main control FSM of the multi-cycle MIPS datapath; the driving end of the ALU interface.
- Issues the 3-bit ALU op code and datapath mux/enable strobes.
- Consumes the ALU zero flag and the memory ready handshake.
- One instruction takes 3-5 states plus memory wait cycles; this block sits between instruction register decode fields and the datapath.

Parameters:
HALT_ON_ILLEGAL, 0, 1 = an illegal instruction parks the FSM in HALT until reset; 0 = pulse illegal and refetch.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
memReady  in  1  memory completes the access this cycle
memRead  out  1  memory read strobe
memWrite  out  1  memory write strobe
iorD  out  1  address select: 0 = PC, 1 = ALUOut
irWrite  out  1  IR load
pcWrite  out  1  PC load (final, branch-resolved)
pcSrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
regWrite  out  1  register file write
regDst  out  2  write register: 00 = rt, 01 = rd, 10 = $31
memToReg  out  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC
aluSrcA  out  1  0 = PC, 1 = regA
aluSrcB  out  2  00 = regB, 01 = const 4, 10 = ext imm, 11 = sign-ext imm << 2
immZext  out  1  1 = zero-extend the immediate
aluOp  out  3  000 = A, 001 = B, 010 = ~B, 100 = add, 101 = sub, 110 = and, 111 = or
illegal  out  1  one-cycle pulse on an unsupported instruction
state  out  4  current state, for debug

Behaviour:
Reset and output defaults:
- rst_n low → state = FETCH immediately (asynchronous).
- While rst_n is low, every enable/strobe is 0, all selects are 0, aluOp = 100 and illegal = 0.
- Reset asserted mid-instruction aborts it; nothing may be written on the reset edge.
- Outputs are decoded from state. pcWrite, irWrite and branch resolution are also combinational on memReady/zero (Mealy).
- Unlisted outputs are 0 and aluOp = 100 in every state.

States and transitions:
- FETCH: memRead = 1, aluSrcA = 0, aluSrcB = 01, aluOp = 100. irWrite = pcWrite = memReady. Stay until memReady, then go to DECODE.
- DECODE: aluSrcA = 0, aluSrcB = 11, aluOp = 100 (branch target into ALUOut). Dispatch on opcode:
  - lw 23h / sw 2Bh → MEM_ADDR
  - R-type 00h: funct 20h/22h/24h/25h → R_EXEC; funct 08h → JR
  - addi 08h / andi 0Ch / ori 0Dh → I_EXEC
  - beq 04h / bne 05h → BRANCH
  - j 02h → JUMP; jal 03h → JAL
  - otherwise: illegal = 1, next state = HALT_ON_ILLEGAL ? HALT : FETCH
- MEM_ADDR: aluSrcA = 1, aluSrcB = 10, aluOp = 100. Next: lw → MEM_RD, sw → MEM_WR.
- MEM_RD: iorD = 1, memRead = 1. Hold until memReady, then MEM_WB.
- MEM_WB: regDst = 00, memToReg = 01, regWrite = 1. Next FETCH.
- MEM_WR: iorD = 1, memWrite = 1. Hold until memReady, then FETCH.
- R_EXEC: aluSrcA = 1, aluSrcB = 00. aluOp: 20h → 100, 22h → 101, 24h → 110, 25h → 111. Next R_WB.
- R_WB: regDst = 01, memToReg = 00, regWrite = 1. Next FETCH.
- I_EXEC: aluSrcA = 1, aluSrcB = 10. addi: aluOp = 100, immZext = 0. andi: 110, immZext = 1. ori: 111, immZext = 1. Next I_WB.
- I_WB: regDst = 00, memToReg = 00, regWrite = 1, immZext held as in I_EXEC. Next FETCH.
- BRANCH: aluSrcA = 1, aluSrcB = 00, aluOp = 101, pcSrc = 01. pcWrite = zero for beq, ~zero for bne. Next FETCH.
- JUMP: pcSrc = 10, pcWrite = 1. Next FETCH.
- JAL: pcSrc = 10, pcWrite = 1, regWrite = 1, regDst = 10, memToReg = 10. The PC already holds PC+4. Next FETCH.
- JR: aluSrcA = 1, aluOp = 000 (pass A), pcSrc = 00, pcWrite = 1. Next FETCH.
- HALT: all outputs at defaults; exit only by reset.

Boundary conditions:
- opcode and funct are sampled only in DECODE/EXEC states and are stable from IR.
- The opcode registered at DECODE selects the state path; R_EXEC/I_EXEC/I_WB/BRANCH re-read opcode/funct from the held IR.
- memReady outside FETCH/MEM_RD/MEM_WR is ignored.
- memReady held low → unbounded stall with strobes held high.
- The X/Z ALU codes (011) are never driven.

Latency (with memReady = 1):
- lw 5 cycles; sw, R-type and I-type 4 cycles; beq/bne, j, jal and jr 3 cycles.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum (4-bit encodings)
  - ALU op constants (ALU_PASS_A, ALU_PASS_B, ALU_NOT_B, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR)
  - opcode/funct constants
  - pcSrc/regDst/memToReg/aluSrcB select constants
- One natural sub-module, mips_alu_op_dec: combinational state + opcode + funct → aluOp and immZext.

Test Plan:
- Reset: hold rst_n low mid-MEM_WR → all strobes 0 immediately. Release → state = FETCH; with memReady = 1 the first edge gives irWrite = pcWrite = 1.
- lw with memReady low for 3 cycles in MEM_RD → memRead held for 4 cycles. Sequence FETCH, DECODE, MEM_ADDR, MEM_RD×4, MEM_WB; regWrite = 1 with regDst = 00 and memToReg = 01 exactly once.
- R-type funct 22h → R_EXEC with aluOp = 101 and aluSrcB = 00, then R_WB with regDst = 01; funct 25h → aluOp = 111.
- beq with zero = 1 → pcWrite = 1 and pcSrc = 01 in BRANCH. bne with zero = 1 → pcWrite = 0. Both return to FETCH next cycle.
- jal → JAL with regDst = 10, memToReg = 10, pcSrc = 10 and pcWrite = regWrite = 1. jr (funct 08h) → aluOp = 000, pcSrc = 00.
- Opcode 3Fh → illegal pulses 1 cycle. With HALT_ON_ILLEGAL = 0 the next state is FETCH; with 1 the FSM stays in HALT for 10 cycles with no strobes until rst_n is pulsed.
